// File: rtl/register_types.sv
// Shared register-select definitions for the CPU datapath.
// cmd_t encodes NONE (0) and r0..r7 (1..8); 9..15 are illegal encodings.
// sel_valid() flags r0..r7, sel_idx() maps a valid selector to its storage index.
package register_types;

  localparam int unsigned NUM_REGS = 8;
  localparam int unsigned IDX_W    = 3;
  localparam int unsigned SEL_W    = 4;

  typedef enum logic [SEL_W-1:0] {
    NONE = 4'd0,
    R0   = 4'd1,
    R1   = 4'd2,
    R2   = 4'd3,
    R3   = 4'd4,
    R4   = 4'd5,
    R5   = 4'd6,
    R6   = 4'd7,
    R7   = 4'd8
  } cmd_t;

  // True only for r0..r7; NONE and 9..15 are "no register".
  function automatic logic sel_valid(input cmd_t sel);
    return (SEL_W'(sel) >= SEL_W'(R0)) && (SEL_W'(sel) <= SEL_W'(R7));
  endfunction

  // Storage index of a selector; only meaningful when sel_valid() is true.
  function automatic logic [IDX_W-1:0] sel_idx(input cmd_t sel);
    return IDX_W'(SEL_W'(sel) - SEL_W'(1));
  endfunction

  // Encodings 9..15 are illegal.
  function automatic logic sel_illegal(input cmd_t sel);
    return SEL_W'(sel) > SEL_W'(R7);
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one pending bit per register and the issue stall.
// Ports: clk, rst_n; rd_sel_a/rd_sel_b read selectors; wr_en/wr_sel write-back
// (clears pending); iss_en/iss_sel issue (sets pending); stall (combinational).
// Macro REG_FILE_BYPASS_EN: RAW hazards on the register being written back
// this cycle are suppressed, since the read port forwards wr_data.
module reg_scoreboard
  import register_types::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [SEL_W-1:0] rd_sel_a,
  input  logic [SEL_W-1:0] rd_sel_b,
  input  logic             wr_en,
  input  logic [SEL_W-1:0] wr_sel,
  input  logic             iss_en,
  input  logic [SEL_W-1:0] iss_sel,
  output logic             stall
);

  logic [NUM_REGS-1:0] pending;
  logic [NUM_REGS-1:0] set_mask;
  logic [NUM_REGS-1:0] clr_mask;
  logic                raw_a;
  logic                raw_b;
  logic                waw;

  // One-hot set/clear requests from issue and write-back.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (iss_en && sel_valid(cmd_t'(iss_sel))) set_mask[sel_idx(cmd_t'(iss_sel))] = 1'b1;
    if (wr_en && sel_valid(cmd_t'(wr_sel)))   clr_mask[sel_idx(cmd_t'(wr_sel))]   = 1'b1;
  end

  // Set is applied after clear so a same-register issue stays outstanding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending <= '0;
    else        pending <= (pending & ~clr_mask) | set_mask;
  end

  // Hazard detection on the current selectors.
  always_comb begin
    raw_a = sel_valid(cmd_t'(rd_sel_a)) && pending[sel_idx(cmd_t'(rd_sel_a))];
    raw_b = sel_valid(cmd_t'(rd_sel_b)) && pending[sel_idx(cmd_t'(rd_sel_b))];
`ifdef REG_FILE_BYPASS_EN
    if (wr_en && (wr_sel == rd_sel_a)) raw_a = 1'b0;
    if (wr_en && (wr_sel == rd_sel_b)) raw_b = 1'b0;
`endif
    waw   = iss_en && sel_valid(cmd_t'(iss_sel)) && pending[sel_idx(cmd_t'(iss_sel))];
    stall = raw_a || raw_b || waw;
  end

endmodule

// File: rtl/reg_file.sv
// Eight-entry register file: two registered read ports, one write port,
// pending-write scoreboard (reg_scoreboard) and a sticky illegal-selector flag.
// Ports: clk, rst_n; rd_sel_a/b -> rd_data_a/b (1-cycle latency); wr_en,
// wr_sel, wr_data write-back; iss_en, iss_sel issue; stall (combinational);
// sel_err (sticky until reset).
// Macro REG_FILE_BYPASS_EN: same-cycle write/read of one register forwards
// wr_data to the read port; otherwise the read returns the pre-write value.
module reg_file
  import register_types::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [SEL_W-1:0] rd_sel_a,
  input  logic [SEL_W-1:0] rd_sel_b,
  output logic [WIDTH-1:0] rd_data_a,
  output logic [WIDTH-1:0] rd_data_b,
  input  logic             wr_en,
  input  logic [SEL_W-1:0] wr_sel,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             iss_en,
  input  logic [SEL_W-1:0] iss_sel,
  output logic             stall,
  output logic             sel_err
);

  logic [WIDTH-1:0] regs [NUM_REGS];
  logic [WIDTH-1:0] rd_next_a;
  logic [WIDTH-1:0] rd_next_b;
  logic             wr_valid;
  logic             err_now;

  assign wr_valid = wr_en && sel_valid(cmd_t'(wr_sel));
  assign err_now  = sel_illegal(cmd_t'(rd_sel_a)) || sel_illegal(cmd_t'(rd_sel_b)) ||
                    (wr_en && sel_illegal(cmd_t'(wr_sel))) ||
                    (iss_en && sel_illegal(cmd_t'(iss_sel)));

  // Read-port next values; "no register" selectors read as zero.
  always_comb begin
    rd_next_a = '0;
    rd_next_b = '0;
    if (sel_valid(cmd_t'(rd_sel_a))) rd_next_a = regs[sel_idx(cmd_t'(rd_sel_a))];
    if (sel_valid(cmd_t'(rd_sel_b))) rd_next_b = regs[sel_idx(cmd_t'(rd_sel_b))];
`ifdef REG_FILE_BYPASS_EN
    if (wr_valid && (wr_sel == rd_sel_a)) rd_next_a = wr_data;
    if (wr_valid && (wr_sel == rd_sel_b)) rd_next_b = wr_data;
`endif
  end

  // Storage, read registers and sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      rd_data_a <= '0;
      rd_data_b <= '0;
      sel_err   <= 1'b0;
    end else begin
      if (wr_valid) regs[sel_idx(cmd_t'(wr_sel))] <= wr_data;
      rd_data_a <= rd_next_a;
      rd_data_b <= rd_next_b;
      if (err_now) sel_err <= 1'b1;
    end
  end

  reg_scoreboard u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_sel_a (rd_sel_a),
    .rd_sel_b (rd_sel_b),
    .wr_en    (wr_en),
    .wr_sel   (wr_sel),
    .iss_en   (iss_en),
    .iss_sel  (iss_sel),
    .stall    (stall)
  );

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed scenarios plus randomized traffic
// checked against an array-based reference model of the register file.
// Honours REG_FILE_BYPASS_EN for the same-cycle write/read expectation.
module tb_reg_file;

  logic        clk;
  logic        rst_n;
  logic [3:0]  rd_sel_a, rd_sel_b, wr_sel, iss_sel;
  logic [15:0] rd_data_a, rd_data_b, wr_data;
  logic        wr_en, iss_en, stall, sel_err;

  int checks = 0;
  int errors = 0;

`ifdef REG_FILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  reg_file #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .rd_sel_a(rd_sel_a), .rd_sel_b(rd_sel_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
    .iss_en(iss_en), .iss_sel(iss_sel),
    .stall(stall), .sel_err(sel_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [15:0] m_regs [8];
  bit          m_pend [8];
  bit          m_err;
  logic [15:0] exp_a, exp_b;

  function automatic bit is_reg(input logic [3:0] s);
    return (s >= 4'd1) && (s <= 4'd8);
  endfunction

  function automatic int ix(input logic [3:0] s);
    return int'(s) - 1;
  endfunction

  function automatic logic [15:0] model_read(input logic [3:0] s);
    if (!is_reg(s)) return 16'h0;
    if (BYP && wr_en && wr_sel == s) return wr_data;
    return m_regs[ix(s)];
  endfunction

  function automatic bit model_stall();
    bit h = 1'b0;
    if (is_reg(rd_sel_a) && m_pend[ix(rd_sel_a)] && !(BYP && wr_en && wr_sel == rd_sel_a)) h = 1'b1;
    if (is_reg(rd_sel_b) && m_pend[ix(rd_sel_b)] && !(BYP && wr_en && wr_sel == rd_sel_b)) h = 1'b1;
    if (iss_en && is_reg(iss_sel) && m_pend[ix(iss_sel)]) h = 1'b1;
    return h;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_regs[i] = 16'h0;
      m_pend[i] = 1'b0;
    end
    m_err = 1'b0;
    exp_a = 16'h0;
    exp_b = 16'h0;
  endtask

  // Advance the model by one clock using the currently driven inputs.
  task automatic model_clock();
    if (!rst_n) begin
      model_reset();
    end else begin
      exp_a = model_read(rd_sel_a);
      exp_b = model_read(rd_sel_b);
      if (rd_sel_a > 4'd8 || rd_sel_b > 4'd8 || (wr_en && wr_sel > 4'd8) || (iss_en && iss_sel > 4'd8))
        m_err = 1'b1;
      if (wr_en && is_reg(wr_sel)) begin
        m_regs[ix(wr_sel)] = wr_data;
        m_pend[ix(wr_sel)] = 1'b0;
      end
      if (iss_en && is_reg(iss_sel)) m_pend[ix(iss_sel)] = 1'b1;
    end
  endtask

  task automatic tick();
    model_clock();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rd_sel_a = 4'd0; rd_sel_b = 4'd0;
    wr_en = 1'b0; wr_sel = 4'd0; wr_data = 16'h0;
    iss_en = 1'b0; iss_sel = 4'd0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    for (int s = 1; s <= 8; s++) begin
      rd_sel_a = 4'(s);
      rd_sel_b = 4'(9 - s);
      tick();
      checks++;
      if (rd_data_a !== 16'h0 || rd_data_b !== 16'h0) begin
        errors++;
        $display("FAIL reset_read sel=%0d: got a=%h b=%h expected 0000", s, rd_data_a, rd_data_b);
      end
      checks++;
      if (stall !== 1'b0 || sel_err !== 1'b0) begin
        errors++;
        $display("FAIL reset_flags: got stall=%b sel_err=%b expected 0 0", stall, sel_err);
      end
    end
    rst_n = 1'b1;
    idle();
  endtask

  task automatic test_write_read();
    wr_en = 1'b1; wr_sel = 4'd4; wr_data = 16'hBEEF;
    tick();
    idle();
    rd_sel_a = 4'd4; rd_sel_b = 4'd4;
    tick();
    checks++;
    if (rd_data_a !== 16'hBEEF || rd_data_b !== 16'hBEEF) begin
      errors++;
      $display("FAIL write_read_r3: got a=%h b=%h expected beef", rd_data_a, rd_data_b);
    end
    idle();
  endtask

  task automatic test_illegal();
    wr_en = 1'b1; wr_sel = 4'd0; wr_data = 16'h1234;
    tick();
    idle();
    for (int s = 1; s <= 8; s++) begin
      rd_sel_a = 4'(s);
      tick();
      checks++;
      if (rd_data_a !== exp_a || rd_data_a === 16'h1234) begin
        errors++;
        $display("FAIL none_write sel=%0d: got %h expected %h", s, rd_data_a, exp_a);
      end
    end
    checks++;
    if (sel_err !== 1'b0) begin
      errors++;
      $display("FAIL none_no_err: got sel_err=%b expected 0", sel_err);
    end
    rd_sel_a = 4'd12;
    tick();
    checks++;
    if (rd_data_a !== 16'h0 || sel_err !== 1'b1) begin
      errors++;
      $display("FAIL illegal_read: got data=%h sel_err=%b expected 0000 1", rd_data_a, sel_err);
    end
    rd_sel_a = 4'd2;
    tick();
    tick();
    checks++;
    if (sel_err !== 1'b1) begin
      errors++;
      $display("FAIL sel_err_sticky: got %b expected 1", sel_err);
    end
    do_reset();
    checks++;
    if (sel_err !== 1'b0) begin
      errors++;
      $display("FAIL sel_err_reset: got %b expected 0", sel_err);
    end
  endtask

  task automatic test_scoreboard();
    idle();
    iss_en = 1'b1; iss_sel = 4'd6;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL issue_clean: got stall=%b expected 0", stall);
    end
    tick();
    idle();
    rd_sel_a = 4'd6;
    #1;
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("FAIL raw_r5: got stall=%b expected 1", stall);
    end
    idle();
    iss_en = 1'b1; iss_sel = 4'd6;
    #1;
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("FAIL waw_r5: got stall=%b expected 1", stall);
    end
    idle();
    wr_en = 1'b1; wr_sel = 4'd6; wr_data = 16'h5555;
    tick();
    idle();
    rd_sel_a = 4'd6;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL writeback_clears: got stall=%b expected 0", stall);
    end
    idle();
    iss_en = 1'b1; iss_sel = 4'd6;
    wr_en = 1'b1; wr_sel = 4'd6; wr_data = 16'h6666;
    tick();
    idle();
    rd_sel_b = 4'd6;
    #1;
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("FAIL set_wins: got stall=%b expected 1", stall);
    end
    idle();
    wr_en = 1'b1; wr_sel = 4'd6; wr_data = 16'h7777;
    tick();
    idle();
  endtask

  task automatic test_bypass();
    wr_en = 1'b1; wr_sel = 4'd2; wr_data = 16'h0011;
    tick();
    wr_data = 16'h00AA;
    rd_sel_a = 4'd2; rd_sel_b = 4'd2;
    tick();
    wr_en = 1'b0;
    checks++;
    if (rd_data_a !== (BYP ? 16'h00AA : 16'h0011) || rd_data_b !== rd_data_a) begin
      errors++;
      $display("FAIL bypass_same_cycle: got a=%h b=%h expected %h",
               rd_data_a, rd_data_b, BYP ? 16'h00AA : 16'h0011);
    end
    tick();
    checks++;
    if (rd_data_a !== 16'h00AA) begin
      errors++;
      $display("FAIL bypass_next_read: got %h expected 00aa", rd_data_a);
    end
    idle();
  endtask

  function automatic logic [3:0] rand_sel();
    if ($urandom_range(0, 9) < 8) return 4'($urandom_range(1, 8));
    return 4'($urandom_range(0, 15));
  endfunction

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 400; n++) begin
      rd_sel_a = rand_sel();
      rd_sel_b = rand_sel();
      wr_en    = ($urandom_range(0, 1) == 1);
      wr_sel   = rand_sel();
      wr_data  = 16'($urandom);
      iss_en   = ($urandom_range(0, 2) == 0);
      iss_sel  = rand_sel();
      #1;
      checks++;
      if (stall !== model_stall()) begin
        errors++;
        $display("FAIL rand_stall n=%0d: got %b expected %b", n, stall, model_stall());
      end
      tick();
      checks++;
      if (rd_data_a !== exp_a) begin
        errors++;
        $display("FAIL rand_rd_a n=%0d: got %h expected %h", n, rd_data_a, exp_a);
      end
      checks++;
      if (rd_data_b !== exp_b) begin
        errors++;
        $display("FAIL rand_rd_b n=%0d: got %h expected %h", n, rd_data_b, exp_b);
      end
      checks++;
      if (sel_err !== m_err) begin
        errors++;
        $display("FAIL rand_sel_err n=%0d: got %b expected %b", n, sel_err, m_err);
      end
    end
    idle();
  endtask

  task automatic test_reset_midrun();
    do_reset();
    wr_en = 1'b1; wr_sel = 4'd3; wr_data = 16'hC0DE;
    tick();
    idle();
    iss_en = 1'b1; iss_sel = 4'd3;
    tick();
    idle();
    rd_sel_a = 4'd3; rd_sel_b = 4'd3;
    tick();
    checks++;
    if (rd_data_a !== 16'hC0DE || stall !== 1'b1) begin
      errors++;
      $display("FAIL midrun_setup: got data=%h stall=%b expected c0de 1", rd_data_a, stall);
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (rd_data_a !== 16'h0 || rd_data_b !== 16'h0 || stall !== 1'b0 || sel_err !== 1'b0) begin
      errors++;
      $display("FAIL midrun_reset: got a=%h b=%h stall=%b err=%b expected 0 0 0 0",
               rd_data_a, rd_data_b, stall, sel_err);
    end
    model_reset();
    idle();
    tick();
    rst_n = 1'b1;
    rd_sel_a = 4'd3;
    tick();
    checks++;
    if (rd_data_a !== 16'h0 || stall !== 1'b0) begin
      errors++;
      $display("FAIL midrun_cleared: got data=%h stall=%b expected 0000 0", rd_data_a, stall);
    end
    idle();
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    model_reset();
    test_reset();
    test_write_read();
    test_illegal();
    test_scoreboard();
    test_bypass();
    test_random();
    test_reset_midrun();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
